cpu_fabric_mailbox: RTL and testbench

Bridges the CPU register bus to the 16-bit CPU interface lines that the fabric exposes at the fabric edge. It consumes the fabric-driven 16-bit word and produces the 16-bit word fed back into the fabric. It carries byte streams in both directions using toggle handshakes across the asynchronous fabric/CPU boundary, and passes 6 GPIO bits each way. All logic is in the CPU clock domain, with input synchronizers on the fabric word.

---
 rtl/cpu_fabric_mailbox.sv | 167 ++++++++++++++++
 tb/tb_cpu_fabric_mailbox.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cpu_fabric_mailbox.sv
// CPU register-bus mailbox to the fabric CPU interface word: byte FIFOs each way
// with toggle handshakes, plus 6 GPIO bits each way. Everything runs on clk_i.
module cpu_fabric_mailbox #(
  parameter int RX_DEPTH    = 4,
  parameter int TX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_valid_i,
  input  logic        bus_we_i,
  input  logic [1:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_ready_o,
  output logic        irq_o,
  input  logic [15:0] fabric_i,
  output logic [15:0] fabric_o
);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam logic [RXAW:0] RX_FULL_CNT = (RXAW+1)'(RX_DEPTH);
  localparam logic [TXAW:0] TX_FULL_CNT = (TXAW+1)'(TX_DEPTH);

  typedef enum logic {IDLE, WAIT_ACK} txState_t;

  logic [15:0]   syncQ [SYNC_STAGES];
  logic [15:0]   fabSync;
  logic [7:0]    rxMem [RX_DEPTH];
  logic [RXAW-1:0] rxWr, rxRd;
  logic [RXAW:0] rxCount;
  logic [7:0]    txMem [TX_DEPTH];
  logic [TXAW-1:0] txWr, txRd;
  logic [TXAW:0] txCount;
  logic          rxSeen, txTgl, txOvf, rxUnd;
  logic [7:0]    dataQ;
  logic [5:0]    gpioOut;
  txState_t      state, stateNext;
  logic          txPop, txBusy;
  logic [31:0]   rdNext, status;

  // Fabric word synchronizer chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
    end else begin
      syncQ[0] <= fabric_i;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
  end
  assign fabSync = syncQ[SYNC_STAGES-1];

  logic accept, dataWr, dataRd, statWr, gpioWr;
  assign accept = bus_valid_i & ~bus_ready_o;
  assign dataWr = accept &  bus_we_i & (bus_addr_i == 2'd0);
  assign dataRd = accept & ~bus_we_i & (bus_addr_i == 2'd0);
  assign statWr = accept &  bus_we_i & (bus_addr_i == 2'd1);
  assign gpioWr = accept &  bus_we_i & (bus_addr_i == 2'd2);

  logic rxEmpty, rxFull, rxPush, rxPop;
  logic txEmpty, txFull, txPush, txDrop;
  assign rxEmpty = (rxCount == '0);
  assign rxFull  = (rxCount == RX_FULL_CNT);
  assign txEmpty = (txCount == '0);
  assign txFull  = (txCount == TX_FULL_CNT);
  // A pending fabric byte is held (not acked) while the RX FIFO is full
  assign rxPush  = (fabSync[8] ^ rxSeen) & ~rxFull;
  assign rxPop   = dataRd & ~rxEmpty;
  assign txPush  = dataWr & (~txFull | txPop);
  assign txDrop  = dataWr & txFull & ~txPop;

  always_ff @(posedge clk_i) begin
    if (rxPush) rxMem[rxWr] <= fabSync[7:0];
    if (txPush) txMem[txWr] <= bus_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxWr <= '0; rxRd <= '0; rxCount <= '0; rxSeen <= 1'b0;
      txWr <= '0; txRd <= '0; txCount <= '0;
    end else begin
      if (rxPush) begin
        rxWr   <= rxWr + 1'b1;
        rxSeen <= fabSync[8];
      end
      if (rxPop) rxRd <= rxRd + 1'b1;
      case ({rxPush, rxPop})
        2'b10:   rxCount <= rxCount + 1'b1;
        2'b01:   rxCount <= rxCount - 1'b1;
        default: ;
      endcase
      if (txPush) txWr <= txWr + 1'b1;
      if (txPop)  txRd <= txRd + 1'b1;
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + 1'b1;
        2'b01:   txCount <= txCount - 1'b1;
        default: ;
      endcase
    end
  end

  // TX handshake FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (!txEmpty) stateNext = WAIT_ACK;
      WAIT_ACK: if (fabSync[9] == txTgl) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_comb begin
    txPop  = (state == IDLE) & ~txEmpty;
    txBusy = (state == WAIT_ACK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dataQ <= '0; txTgl <= 1'b0; txOvf <= 1'b0; rxUnd <= 1'b0; gpioOut <= '0;
    end else begin
      if (txPop) begin
        dataQ <= txMem[txRd];
        txTgl <= ~txTgl;
      end
      // Sticky set beats a same-edge W1C clear
      if (txDrop)                          txOvf <= 1'b1;
      else if (statWr && bus_wdata_i[5])   txOvf <= 1'b0;
      if (dataRd && rxEmpty)               rxUnd <= 1'b1;
      else if (statWr && bus_wdata_i[6])   rxUnd <= 1'b0;
      if (gpioWr) gpioOut <= bus_wdata_i[5:0];
    end
  end

  assign status = {8'd0, 8'(txCount), 8'(rxCount), 1'b0, rxUnd, txOvf, txBusy,
                   txFull, txEmpty, rxFull, rxEmpty};

  always_comb begin
    rdNext = '0;
    if (!bus_we_i) begin
      case (bus_addr_i)
        2'd0: rdNext = rxEmpty ? 32'd0 : {24'd0, rxMem[rxRd]};
        2'd1: rdNext = status;
        2'd2: rdNext = {26'd0, gpioOut};
        2'd3: rdNext = {26'd0, fabSync[15:10]};
        default: rdNext = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_ready_o <= 1'b0;
      bus_rdata_o <= '0;
    end else begin
      bus_ready_o <= accept;
      bus_rdata_o <= accept ? rdNext : 32'd0;
    end
  end

  assign irq_o    = ~rxEmpty;
  assign fabric_o = {gpioOut, rxSeen, txTgl, dataQ};
endmodule

// File: tb/tb_cpu_fabric_mailbox.sv
// Directed bench for cpu_fabric_mailbox: bus register access, TX/RX handshakes,
// FIFO overflow/underflow, GPIO and reset during a transfer.
module tb_cpu_fabric_mailbox;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busValid = 1'b0;
  logic        busWe = 1'b0;
  logic [1:0]  busAddr = 2'd0;
  logic [31:0] busWdata = 32'd0;
  logic [31:0] busRdata;
  logic        busReady;
  logic        irq;
  logic [15:0] fab = 16'hFFFF;
  logic [15:0] fabOut;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] rd;

  cpu_fabric_mailbox #(.RX_DEPTH(4), .TX_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus_valid_i(busValid), .bus_we_i(busWe),
    .bus_addr_i(busAddr), .bus_wdata_i(busWdata), .bus_rdata_o(busRdata),
    .bus_ready_o(busReady), .irq_o(irq), .fabric_i(fab), .fabric_o(fabOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busTx(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdOut);
    logic got;
    busValid = 1'b1; busWe = we; busAddr = addr; busWdata = wd;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (busReady) got = 1'b1;
    end
    rdOut = busRdata;
    busValid = 1'b0;
    if (!got) chk("busTimeout", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    busTx(1'b1, addr, wd, dummy);
  endtask

  task automatic rdReg(input logic [1:0] addr, output logic [31:0] v);
    busTx(1'b0, addr, 32'd0, v);
  endtask

  task automatic sendByte(input logic [7:0] b);
    fab[7:0] = b;
    fab[8]   = ~fab[8];
    for (int i = 0; i < 10 && fabOut[9] !== fab[8]; i++) cyc(1);
    chk("rxAck", 32'(fabOut[9]), 32'(fab[8]));
  endtask

  initial begin
    // Reset with fabric lines all high
    cyc(3);
    chk("rstFabricO", 32'(fabOut), 32'd0);
    chk("rstReady", 32'(busReady), 32'd0);
    chk("rstRdata", busRdata, 32'd0);
    chk("rstIrq", 32'(irq), 32'd0);
    fab = 16'h0000;
    rst = 1'b0;
    cyc(3);
    rdReg(2'd1, rd); chk("statusAfterReset", rd, 32'h0000_0005);

    // GPIO
    wr(2'd2, 32'h2A);
    cyc(1);
    chk("gpioOutPins", 32'(fabOut[15:10]), 32'h2A);
    rdReg(2'd2, rd); chk("gpioOutRead", rd, 32'h2A);
    fab[15:10] = 6'h15;
    cyc(3);
    rdReg(2'd3, rd); chk("gpioIn", rd, 32'h15);

    // TX two bytes
    wr(2'd0, 32'hA5);
    chk("txNotYet", 32'(fabOut[8]), 32'd0);
    wr(2'd0, 32'h3C);
    rdReg(2'd1, rd); chk("statusTx1", rd, 32'h0001_0011);
    chk("txByte1", 32'(fabOut[8:0]), 32'h1A5);
    fab[9] = 1'b1;
    cyc(4);
    chk("txByte2", 32'(fabOut[8:0]), 32'h03C);
    rdReg(2'd1, rd); chk("statusTx2", rd, 32'h0000_0015);
    fab[9] = 1'b0;
    cyc(4);
    rdReg(2'd1, rd); chk("statusTxDone", rd, 32'h0000_0005);

    // RX with overflow back-pressure
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    fab[7:0] = 8'h05;
    fab[8]   = ~fab[8];
    cyc(8);
    chk("rxHeld", 32'(fabOut[9]), 32'd0);
    chk("irqRx", 32'(irq), 32'd1);
    rdReg(2'd1, rd); chk("statusRxFull", rd, 32'h0000_0406);
    rdReg(2'd0, rd); chk("rxRead1", rd, 32'h01);
    cyc(3);
    chk("rxAck5", 32'(fabOut[9]), 32'd1);
    rdReg(2'd0, rd); chk("rxRead2", rd, 32'h02);
    rdReg(2'd0, rd); chk("rxRead3", rd, 32'h03);
    rdReg(2'd0, rd); chk("rxRead4", rd, 32'h04);
    rdReg(2'd0, rd); chk("rxRead5", rd, 32'h05);
    chk("irqClear", 32'(irq), 32'd0);

    // Underflow and TX overflow (first byte launches, so six writes overfill)
    rdReg(2'd0, rd); chk("underflowData", rd, 32'd0);
    rdReg(2'd1, rd); chk("statusUnder", rd, 32'h0000_0045);
    for (int i = 0; i < 6; i++) wr(2'd0, 32'h11 + 32'(i));
    rdReg(2'd1, rd); chk("statusOver", rd, 32'h0004_0079);
    wr(2'd1, 32'h60);
    rdReg(2'd1, rd); chk("statusW1C", rd, 32'h0004_0019);
    chk("txHeadByte", 32'(fabOut[8:0]), 32'h111);

    // Reset while waiting for ack
    rst = 1'b1;
    fab = 16'h0000;
    #1;
    chk("midRstFabricO", 32'(fabOut), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    rdReg(2'd1, rd); chk("statusPostRst", rd, 32'h0000_0005);
    wr(2'd0, 32'h77);
    cyc(1);
    chk("txAfterRst", 32'(fabOut[8:0]), 32'h177);
    fab[9] = 1'b1;
    cyc(4);
    rdReg(2'd1, rd); chk("statusFinal", rd, 32'h0000_0005);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
